// File: rtl/game_flow_controller.sv
// game_flow_controller
//   Top-level game sequencer. Gates the alien/laser datapath, re-arms the alien
//   grid for each wave, and owns lives, level and score.
// Ports
//   clk, reset     system clock, asynchronous active-high reset
//   tick           1-cycle time-unit pulse used as the pause timebase
//   fire           debounced 1-cycle fire pulse (starts a game from ATTRACT)
//   victory        level: all aliens dead
//   defeat         level: aliens reached the ship row
//   ship_hit       1-cycle pulse: ship struck
//   killing_alien  1-cycle pulse: laser killed an alien
//   play_en        high only in PLAYING
//   wave_reset     1-cycle pulse in START: reload alien grid and laser
//   level          current wave, saturating at MAX_LEVEL
//   lives          remaining lives
//   score          saturating binary score
//   game_over      high while in GAME_OVER
//   state          encoded FSM state for HUD/debug
module game_flow_controller #(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned MAX_LEVEL   = 7,
    parameter int unsigned PAUSE_TICKS = 30,
    parameter int unsigned POINTS      = 10,
    parameter int unsigned SCORE_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               fire,
    input  logic               victory,
    input  logic               defeat,
    input  logic               ship_hit,
    input  logic               killing_alien,
    output logic               play_en,
    output logic               wave_reset,
    output logic [2:0]         level,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [2:0]         state
);

    localparam int unsigned CNT_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

    typedef enum logic [2:0] {
        ATTRACT    = 3'd0,
        START      = 3'd1,
        PLAYING    = 3'd2,
        WAVE_CLEAR = 3'd3,
        SHIP_LOST  = 3'd4,
        GAME_OVER  = 3'd5
    } stateT;

    stateT              stateQ;
    stateT              stateNext;
    logic [CNT_W-1:0]   pauseCnt;
    logic               pauseArmed;
    logic               pausing;
    logic               pauseDone;
    logic [SCORE_W:0]   scoreSum;

    assign state = stateQ;

    assign pausing = (stateQ == WAVE_CLEAR) || (stateQ == SHIP_LOST) || (stateQ == GAME_OVER);

    // pauseArmed stays low for the entry cycle so a tick there is not counted
    assign pauseDone = pausing && pauseArmed && tick &&
                       (pauseCnt == CNT_W'(PAUSE_TICKS - 1));

    // One extra bit catches the carry for saturation
    assign scoreSum = {1'b0, score} + (SCORE_W + 1)'(POINTS);

    // Next-state selection; defeat > ship_hit > victory while playing
    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            ATTRACT:    if (fire) stateNext = START;
            START:      stateNext = PLAYING;
            PLAYING: begin
                if (defeat)
                    stateNext = GAME_OVER;
                else if (ship_hit)
                    stateNext = (lives == 3'd1) ? GAME_OVER : SHIP_LOST;
                else if (victory)
                    stateNext = WAVE_CLEAR;
            end
            WAVE_CLEAR: if (pauseDone) stateNext = START;
            SHIP_LOST:  if (pauseDone) stateNext = PLAYING;
            GAME_OVER:  if (pauseDone) stateNext = ATTRACT;
            default:    stateNext = ATTRACT;
        endcase
    end

    // State, registered decodes, pause timer and game counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ     <= ATTRACT;
            play_en    <= 1'b0;
            wave_reset <= 1'b0;
            game_over  <= 1'b0;
            level      <= 3'd0;
            lives      <= 3'(LIVES_INIT);
            score      <= '0;
            pauseCnt   <= '0;
            pauseArmed <= 1'b0;
        end else begin
            stateQ     <= stateNext;
            play_en    <= (stateNext == PLAYING);
            wave_reset <= (stateNext == START);
            game_over  <= (stateNext == GAME_OVER);

            if (stateNext != stateQ) begin
                pauseCnt   <= '0;
                pauseArmed <= 1'b0;
            end else if (pausing) begin
                if (!pauseArmed)
                    pauseArmed <= 1'b1;
                else if (tick)
                    pauseCnt <= pauseCnt + CNT_W'(1);
            end

            case (stateQ)
                ATTRACT: begin
                    if (fire) begin
                        score <= '0;
                        level <= 3'd0;
                        lives <= 3'(LIVES_INIT);
                    end
                end
                PLAYING: begin
                    // Kills count even on the cycle that leaves PLAYING
                    if (killing_alien)
                        score <= scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
                    if (defeat)
                        lives <= 3'd0;
                    else if (ship_hit)
                        lives <= lives - 3'd1;
                    else if (victory && (level < 3'(MAX_LEVEL)))
                        level <= level + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
